// File: rtl/sram_burst_master.sv
// Burst master for a single-port synchronous SRAM with registered read data.
// Write bursts stream wr_data straight onto the SRAM pins; read bursts are
// throttled so returning words always fit in a 2-entry output FIFO.
module sram_burst_master #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned WORD_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [BITS-1:0]       wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BITS-1:0]       rd_data,
  output logic                  busy,
  output logic                  sram_CEN,
  output logic                  sram_WEN,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic [BITS-1:0]       sram_D,
  input  logic [BITS-1:0]       sram_Q
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  inflight_q, inflight_d;

  logic [BITS-1:0]       fifo_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            count_q;

  logic                  access;
  logic                  issue_rd;
  logic                  push;
  logic                  pop;
  logic [2:0]            level;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // A read issued last cycle always lands in the FIFO this cycle.
  assign push     = inflight_q;
  assign rd_valid = (count_q != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? fifo_q[rptr_q] : '0;
  assign busy     = (state_q != StIdle);

  // Projected FIFO fill once the word in flight lands and the current pop retires.
  assign level    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_rd = (state_q == StRead) && (level < 3'd2);

  assign addr_inc = (addr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  assign sram_CEN = ~access;
  assign sram_A   = addr_q;

  // Next-state, burst bookkeeping and SRAM pin drive.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    access     = 1'b0;
    sram_WEN   = 1'b1;
    sram_D     = '0;
    inflight_d = issue_rd;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = cmd_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          access   = 1'b1;
          sram_WEN = 1'b0;
          sram_D   = wr_data;
          if (rem_q == '0) state_d = StIdle;
        end
      end
      StRead: begin
        if (issue_rd) begin
          access = 1'b1;
          if (rem_q == '0) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (access) begin
      addr_d = addr_inc;
      rem_d  = rem_q - ADDR_WIDTH'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  // Two-entry read-data FIFO; simultaneous push and pop keep the fill level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= sram_Q;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
